vram_loader: RTL and testbench
==============================

Name: vram_loader

Overview:
- Write-side fill engine for the video RAM.
- Runs on write_clk. Walks the image ROM address space once per pass, absorbs the ROM's synchronous read latency and drives the video RAM write port: one byte per cycle, gap-free.
- Supports three sources: ROM copy, constant fill and an address test pattern.
- Replaces the free-running write counter with a bounded pass that has busy/done status.

Parameters:
ADDR_W, 11, width of ROM/RAM word address
DATA_W, 8, data width
DEPTH, 2048, words per pass (1 <= DEPTH <= 2**ADDR_W)
ROM_LAT, 1, ROM read latency in write_clk cycles (>=1)
AUTOSTART, 1, start one pass automatically after reset release
FILL_VALUE, 8'h00, data written in FILL mode

Ports:
write_clk  in  1  write-domain clock
rst  in  1  reset, asynchronous, active-low
start  in  1  single-cycle start pulse, synchronous to write_clk
mode  in  2  0=COPY (ROM), 1=FILL (FILL_VALUE), 2=PATTERN, 3=reserved (treated as COPY)
rom_ce  out  1  ROM read enable
rom_ad  out  ADDR_W  ROM read address
rom_data  in  DATA_W  ROM read data, valid ROM_LAT cycles after rom_ce
ram_ce  out  1  video RAM write enable
ram_ad  out  ADDR_W  video RAM write address
ram_data  out  DATA_W  video RAM write data
busy  out  1  pass in progress (RUN or DRAIN)
done  out  1  last pass finished; level, cleared by next start or reset

Behaviour:
- Reset (rst=0, async):
  - State IDLE; counter, delay line and latched mode all cleared.
  - All outputs 0; armed flag set to AUTOSTART.
- States:
  - IDLE -> RUN when start=1 or armed=1. Latch mode; clear counter and armed.
  - RUN:
    - Counter cnt is the issue address; rom_ad=cnt.
    - rom_ce=1 when latched mode is COPY/reserved, else 0.
    - Push valid=1 plus address cnt into the delay line.
    - cnt increments each cycle. The cycle that issues DEPTH-1 transitions to DRAIN.
  - DRAIN: no issue; rom_ce=0. -> DONE when the delay line holds no valid entry.
  - DONE: done=1, busy=0. start=1 -> RUN (done cleared in the same edge, mode re-latched, cnt=0).
- start during RUN or DRAIN is ignored. mode changes mid-pass are ignored; the latched value governs.
- Delay line:
  - ROM_LAT stages of {valid, addr}.
  - ram_ce = output-stage valid; ram_ad = output-stage addr. Both come directly from registers.
  - ram_data:
    - COPY: rom_data.
    - FILL: FILL_VALUE.
    - PATTERN: ram_ad[DATA_W-1:0] XOR {ram_ad[ADDR_W-1:ADDR_W-3], {(DATA_W-3){1'b0}}}.
- Timing (cycle 0 = first RUN cycle):
  - Write k has ram_ce=1 in cycle k+ROM_LAT, with ram_ad=k.
  - Writes are contiguous: exactly DEPTH writes, addresses 0..DEPTH-1 ascending, no repeats or gaps.
  - DONE is entered at the edge ending cycle DEPTH-1+ROM_LAT, so done=1 in cycle DEPTH+ROM_LAT.
- busy=1 exactly in RUN and DRAIN.
- Address arithmetic is ADDR_W bits, no wrap. The counter stops at DEPTH-1. DEPTH=2**ADDR_W must not overflow the comparison; use an ADDR_W+1-bit compare.
- Reset mid-pass:
  - Everything clears immediately; ram_ce drops asynchronously. The partial image in RAM is left as is.
  - With AUTOSTART=1, a fresh pass starts from address 0 on the first clock after release.
- DEPTH=1: one write at cycle ROM_LAT; done at cycle 1+ROM_LAT.

Decomposition:
- Package vram_loader_pkg:
  - mode constants MODE_COPY/MODE_FILL/MODE_PATTERN.
  - State encoding ST_IDLE/ST_RUN/ST_DRAIN/ST_DONE.
- One sub-module, loader_delay:
  - Parameterised {valid, addr} shift register of depth ROM_LAT, with async active-low clear.
  - Provides an any_valid output used for the DRAIN exit.

Test Plan:
- AUTOSTART=1, DEPTH=16, ROM_LAT=1, ROM model data=addr^8'hA5, mode=0 -> rom_ce cycles 0..15; ram_ce cycles 1..16 with ram_ad 0..15 and data addr^A5; busy 0..16; done=1 from cycle 17.
- mode=1, FILL_VALUE=8'h3C, start pulse -> rom_ce never 1; 16 writes all 8'h3C; done after 17 cycles.
- ROM_LAT=2, DEPTH=16, mode=2 -> first write cycle 2; write at ad=9 carries data 8'h09; ad=15 carries 8'h0F; done at cycle 18.
- start pulsed at RUN cycle 5 and mode toggled to FILL mid-pass -> no restart; all 16 writes stay ROM data. start in DONE -> done drops next cycle, new pass from ad=0.
- rst driven low during write ad=7 -> ram_ce/busy/done go 0 without a clock edge. After release with AUTOSTART=1 -> full 16-write pass from ad=0. With AUTOSTART=0 -> stays IDLE until start.
- DEPTH=1 and DEPTH=2**ADDR_W (ADDR_W=4) -> exactly 1 and 16 writes respectively, no wrap, done asserted once.

Source files
------------

// File: rtl/vram_loader_pkg.sv
// rtl/vram_loader_pkg.sv - shared mode and state encodings for the video RAM fill engine
// Contents:
//   mode_e   : source select (COPY / FILL / PATTERN / reserved)
//   state_e  : fill engine states (IDLE / RUN / DRAIN / DONE)
//   is_copy  : true for modes that read the image ROM
package vram_loader_pkg;

  typedef enum logic [1:0] {
    MODE_COPY    = 2'd0,
    MODE_FILL    = 2'd1,
    MODE_PATTERN = 2'd2,
    MODE_RSVD    = 2'd3
  } mode_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // The reserved encoding behaves exactly like a ROM copy.
  function automatic logic is_copy(input mode_e m);
    return (m == MODE_COPY) || (m == MODE_RSVD);
  endfunction

endpackage

// File: rtl/vram_loader_if.sv
// rtl/vram_loader_if.sv - ROM read port plus video RAM write port of the fill engine
// Signals:
//   rom_ce/rom_ad   : ROM read request (loader -> ROM)
//   rom_data        : ROM read data, ROM_LAT cycles after rom_ce (ROM -> loader)
//   ram_ce/ram_ad/ram_data : video RAM write port (loader -> RAM)
// Modports: master = loader side, slave = memory side.
interface vram_loader_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 8
);

  logic              rom_ce;
  logic [ADDR_W-1:0] rom_ad;
  logic [DATA_W-1:0] rom_data;
  logic              ram_ce;
  logic [ADDR_W-1:0] ram_ad;
  logic [DATA_W-1:0] ram_data;

  modport master (
    output rom_ce, rom_ad,
    input  rom_data,
    output ram_ce, ram_ad, ram_data
  );

  modport slave (
    input  rom_ce, rom_ad,
    output rom_data,
    input  ram_ce, ram_ad, ram_data
  );

endinterface

// File: rtl/vram_loader_delay.sv
// rtl/vram_loader_delay.sv - {valid, addr} delay line matching the ROM read latency
// Ports:
//   write_clk, rst      : clock, asynchronous active-low clear
//   in_valid, in_addr   : entry pushed every cycle
//   out_valid, out_addr : oldest stage, straight from flops
//   any_valid           : an entry is still in flight behind the output stage
module loader_delay #(
  parameter int ADDR_W = 11,
  parameter int LAT    = 1
) (
  input  logic              write_clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_addr,
  output logic              out_valid,
  output logic [ADDR_W-1:0] out_addr,
  output logic              any_valid
);

  logic [LAT-1:0]             valid_q, valid_d;
  logic [LAT-1:0][ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    valid_d    = valid_q;
    addr_d     = addr_q;
    valid_d[0] = in_valid;
    addr_d[0]  = in_addr;
    for (int i = 1; i < LAT; i++) begin
      valid_d[i] = valid_q[i-1];
      addr_d[i]  = addr_q[i-1];
    end
  end

  always_ff @(posedge write_clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign out_valid = valid_q[LAT-1];
  assign out_addr  = addr_q[LAT-1];

  // The output stage is excluded: once only it is valid, the line is empty
  // after the coming edge, which is when the engine may report DONE.
  always_comb begin
    any_valid = 1'b0;
    for (int i = 0; i < LAT - 1; i++) begin
      any_valid = any_valid | valid_q[i];
    end
  end

endmodule

// File: rtl/vram_loader.sv
// rtl/vram_loader.sv - bounded write-side fill engine for the video RAM
// Ports:
//   write_clk : write-domain clock
//   rst       : asynchronous active-low reset
//   start     : single-cycle start pulse
//   mode      : 0=COPY, 1=FILL, 2=PATTERN, 3=reserved (COPY)
//   bus       : ROM read port and video RAM write port (master side)
//   busy      : pass in progress (RUN or DRAIN)
//   done      : last pass finished, held until next start or reset
module vram_loader
  import vram_loader_pkg::*;
#(
  parameter int                ADDR_W     = 11,
  parameter int                DATA_W     = 8,
  parameter int                DEPTH      = 2048,
  parameter int                ROM_LAT    = 1,
  parameter int                AUTOSTART  = 1,
  parameter logic [DATA_W-1:0] FILL_VALUE = 8'h00
) (
  input  logic                write_clk,
  input  logic                rst,
  input  logic                start,
  input  logic [1:0]          mode,
  vram_loader_if.master       bus,
  output logic                busy,
  output logic                done
);

  // One extra bit so DEPTH = 2**ADDR_W still compares correctly.
  localparam logic [ADDR_W:0] LAST = (ADDR_W + 1)'(DEPTH - 1);

  state_e          state_q, state_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  mode_e           mode_q, mode_d;
  logic            armed_q, armed_d;
  logic            issue;

  logic              out_valid;
  logic [ADDR_W-1:0] out_addr;
  logic              any_valid;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    armed_d = armed_q;
    issue   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start || armed_q) begin
          state_d = ST_RUN;
          mode_d  = mode_e'(mode);
          cnt_d   = '0;
          armed_d = 1'b0;
        end
      end
      ST_RUN: begin
        issue = 1'b1;
        if (cnt_q == LAST) begin
          state_d = ST_DRAIN;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        if (!any_valid) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          state_d = ST_RUN;
          mode_d  = mode_e'(mode);
          cnt_d   = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge write_clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      mode_q  <= MODE_COPY;
      armed_q <= (AUTOSTART != 0);
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      armed_q <= armed_d;
    end
  end

  loader_delay #(
    .ADDR_W (ADDR_W),
    .LAT    (ROM_LAT)
  ) u_delay (
    .write_clk (write_clk),
    .rst       (rst),
    .in_valid  (issue),
    .in_addr   (cnt_q[ADDR_W-1:0]),
    .out_valid (out_valid),
    .out_addr  (out_addr),
    .any_valid (any_valid)
  );

  assign busy       = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done       = (state_q == ST_DONE);
  assign bus.rom_ce = issue && is_copy(mode_q);
  assign bus.rom_ad = cnt_q[ADDR_W-1:0];
  assign bus.ram_ce = out_valid;
  assign bus.ram_ad = out_addr;

  // Pattern: low address byte with the top three address bits folded into
  // the top three data bits, so every 1/8 of the image looks different.
  logic [DATA_W-1:0] pattern;
  always_comb begin
    pattern = DATA_W'(out_addr) ^ {out_addr[ADDR_W-1 -: 3], {(DATA_W - 3){1'b0}}};
  end

  // Data is forced to zero between writes so the port is quiet when idle.
  always_comb begin
    bus.ram_data = '0;
    if (out_valid) begin
      case (mode_q)
        MODE_FILL:    bus.ram_data = FILL_VALUE;
        MODE_PATTERN: bus.ram_data = pattern;
        default:      bus.ram_data = bus.rom_data;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_loader.sv
// tb/tb_vram_loader.sv - scoreboard bench for vram_loader over four parameter sets
module tb_vram_loader;

  typedef struct {
    int cyc;
    int ad;
    int dat;
  } wr_t;

  logic            clk = 1'b0;
  int              cyc = 0;
  int              tests = 0;
  int              fails = 0;
  logic [3:0]      rst_s;
  logic [3:0]      start_s;
  logic [3:0][1:0] mode_s;
  logic [3:0]      busy_w;
  logic [3:0]      done_w;
  logic [3:0]      ram_ce_w;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int exp_data(input int m, input int k, input int aw, input int fillv);
    case (m)
      1:       return fillv;
      2:       return (k & 255) ^ (((k >> (aw - 3)) & 7) << 5);
      default: return (k & 255) ^ 8'hA5;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_cfg
    localparam int         AW    = (g >= 2) ? 4 : 11;
    localparam int         DEP   = (g == 3) ? 1 : 16;
    localparam int         LAT   = (g == 1) ? 2 : ((g == 3) ? 3 : 1);
    localparam int         AUTO  = (g == 0 || g == 3) ? 1 : 0;
    localparam logic [7:0] FILLV = (g == 2) ? 8'h5A : 8'h3C;

    vram_loader_if #(.ADDR_W(AW), .DATA_W(8)) bus ();

    vram_loader #(
      .ADDR_W     (AW),
      .DATA_W     (8),
      .DEPTH      (DEP),
      .ROM_LAT    (LAT),
      .AUTOSTART  (AUTO),
      .FILL_VALUE (FILLV)
    ) dut (
      .write_clk (clk),
      .rst       (rst_s[g]),
      .start     (start_s[g]),
      .mode      (mode_s[g]),
      .bus       (bus.master),
      .busy      (busy_w[g]),
      .done      (done_w[g])
    );

    assign ram_ce_w[g] = bus.ram_ce;

    // ROM with LAT-cycle synchronous read; garbage when not enabled.
    logic [LAT-1:0][7:0] rom_pipe;
    always @(posedge clk) begin
      rom_pipe[0] <= bus.rom_ce ? (8'(bus.rom_ad) ^ 8'hA5) : 8'hEE;
      for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
    end
    assign bus.rom_data = rom_pipe[LAT-1];

    // Reference model: 0 idle, 1 pass in progress, 2 finished.
    wr_t q[$];
    int  st    = 0;
    bit  armed = (AUTO != 0);
    int  s     = 0;
    int  last  = 0;
    int  m     = 0;

    always @(posedge clk or negedge rst_s[g]) begin
      if (!rst_s[g]) begin
        st    = 0;
        armed = (AUTO != 0);
        q.delete();
      end else if ((st == 0 && (start_s[g] || armed)) || (st == 2 && start_s[g])) begin
        s     = cyc + 1;
        m     = int'(mode_s[g]);
        armed = 1'b0;
        st    = 1;
        last  = s + DEP - 1 + LAT;
        for (int k = 0; k < DEP; k++) begin
          wr_t w;
          w.cyc = s + k + LAT;
          w.ad  = k;
          w.dat = exp_data(m, k, AW, int'(FILLV));
          q.push_back(w);
        end
      end else if (st == 1 && cyc == last) begin
        st = 2;
      end
    end

    always @(negedge clk) begin : mon
      wr_t w;
      int  rce;
      chk($sformatf("c%0d busy", g), int'(busy_w[g]), (st == 1) ? 1 : 0);
      chk($sformatf("c%0d done", g), int'(done_w[g]), (st == 2) ? 1 : 0);
      rce = (st == 1 && (m == 0 || m == 3) && cyc <= s + DEP - 1) ? 1 : 0;
      chk($sformatf("c%0d rom_ce", g), int'(bus.rom_ce), rce);
      if (rce == 1) chk($sformatf("c%0d rom_ad", g), int'(bus.rom_ad), cyc - s);
      if (q.size() > 0 && q[0].cyc == cyc) begin
        w = q.pop_front();
        chk($sformatf("c%0d ram_ce", g), int'(bus.ram_ce), 1);
        chk($sformatf("c%0d ram_ad", g), int'(bus.ram_ad), w.ad);
        chk($sformatf("c%0d ram_data", g), int'(bus.ram_data), w.dat);
      end else begin
        chk($sformatf("c%0d ram_ce idle", g), int'(bus.ram_ce), 0);
      end
    end
  end

  task automatic pulse_start(input int g, input int md);
    @(negedge clk);
    mode_s[g]  = 2'(md);
    start_s[g] = 1'b1;
    @(negedge clk);
    start_s[g] = 1'b0;
  endtask

  task automatic wait_done(input int g);
    for (int i = 0; i < 400; i++) begin
      if (done_w[g]) return;
      @(negedge clk);
    end
    chk($sformatf("c%0d done timeout", g), int'(done_w[g]), 1);
  endtask

  // Optional stray start and mode change while the pass is running.
  task automatic run_pass(input int g, input int md, input int nd, input int nm);
    pulse_start(g, md);
    if (nd >= 0) begin
      repeat (nd) @(negedge clk);
      mode_s[g]  = 2'(nm);
      start_s[g] = 1'b1;
      @(negedge clk);
      start_s[g] = 1'b0;
    end
    wait_done(g);
  endtask

  task automatic rand_passes(input int g, input int n);
    for (int i = 0; i < n; i++) begin
      run_pass(g, int'($urandom_range(0, 3)), int'($urandom_range(0, 8)) - 1,
               int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_s   = 4'h0;
    start_s = 4'h0;
    mode_s  = '0;
    repeat (3) @(negedge clk);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("c%0d reset busy", g), int'(busy_w[g]), 0);
      chk($sformatf("c%0d reset done", g), int'(done_w[g]), 0);
      chk($sformatf("c%0d reset ram_ce", g), int'(ram_ce_w[g]), 0);
    end
    rst_s = 4'hF;

    // Autostart COPY passes on configs 0 and 3; configs 1 and 2 must idle.
    fork
      wait_done(0);
      wait_done(3);
    join
    chk("c1 idle without start", int'(busy_w[1] | done_w[1]), 0);
    chk("c2 idle without start", int'(busy_w[2] | done_w[2]), 0);

    // FILL, PATTERN and COPY passes, each started from DONE or IDLE.
    fork
      run_pass(0, 1, -1, 0);
      run_pass(1, 2, -1, 0);
      run_pass(2, 2, -1, 0);
      run_pass(3, 2, -1, 0);
    join

    // Stray start at RUN cycle 5 with mode switched to FILL: ignored.
    run_pass(0, 0, 4, 1);

    fork
      rand_passes(0, 6);
      rand_passes(1, 6);
      rand_passes(2, 6);
      rand_passes(3, 8);
    join

    // Asynchronous reset during the write of address 7, autostart restarts.
    pulse_start(0, 0);
    repeat (8) @(posedge clk);
    #1;
    chk("c0 write before reset", int'(ram_ce_w[0]), 1);
    #1;
    rst_s[0] = 1'b0;
    #1;
    chk("c0 async ram_ce", int'(ram_ce_w[0]), 0);
    chk("c0 async busy", int'(busy_w[0]), 0);
    chk("c0 async done", int'(done_w[0]), 0);
    @(negedge clk);
    rst_s[0] = 1'b1;
    wait_done(0);

    // Same on a non-autostart config: it must stay idle until started.
    pulse_start(1, 0);
    repeat (5) @(posedge clk);
    #2;
    rst_s[1] = 1'b0;
    #1;
    chk("c1 async ram_ce", int'(ram_ce_w[1]), 0);
    chk("c1 async busy", int'(busy_w[1]), 0);
    @(negedge clk);
    rst_s[1] = 1'b1;
    repeat (20) @(negedge clk);
    chk("c1 idle after reset", int'(busy_w[1] | done_w[1]), 0);
    run_pass(1, 0, -1, 0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
